// File: rtl/cnn_run_ctrl.sv
// cnn_run_ctrl: board-side run controller that turns a bouncing start button
// into one cnn_start pulse and watches the core's cnn_done under a watchdog.
// Ports:
//   clk_100m   - single clock, rising edge
//   rst_btn_n  - asynchronous active-low reset
//   start_btn  - raw asynchronous button, active high
//   cnn_start  - one-cycle start pulse to the core
//   cnn_done   - completion pulse from the core
//   cnn_result - core result, valid in the cnn_done cycle
//   led_result - latched result, all-ones after a timeout
//   busy       - high while a run is in flight
//   timeout    - sticky: the last run hit the watchdog
//   run_cycles - cycle count of the last completed run
// Optional feature: define CNN_RUN_PERF_EN to build the run_cycles latch;
// otherwise run_cycles is tied to zero.
module cnn_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 20_000,
    parameter int unsigned RESULT_W        = 8
) (
    input  logic                clk_100m,
    input  logic                rst_btn_n,
    input  logic                start_btn,
    output logic                cnn_start,
    input  logic                cnn_done,
    input  logic [RESULT_W-1:0] cnn_result,
    output logic [RESULT_W-1:0] led_result,
    output logic                busy,
    output logic                timeout,
    output logic [31:0]         run_cycles
);
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic                btn_db_q, btn_db_d;
    logic                btn_prev_q, btn_prev_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                cnn_start_q, cnn_start_d;
    logic                timeout_q, timeout_d;
    logic [RESULT_W-1:0] led_q, led_d;
    logic                btn_s;
    logic                req;
    logic                expired;

    assign btn_s   = sync_q[1];
    assign req     = btn_db_q & ~btn_prev_q;
    assign expired = cnt_q >= TO_LIM;

    // Button front end: the debounce counter only runs while the synchronized
    // level disagrees with the accepted level, so any bounce restarts it.
    always_comb begin
        sync_d     = {sync_q[0], start_btn};
        btn_prev_d = btn_db_q;
        btn_db_d   = btn_db_q;
        db_cnt_d   = '0;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST)
                btn_db_d = btn_s;
            else
                db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Run FSM: presses during RUN are dropped, and a done in the same cycle
    // as the watchdog expiry takes priority over the timeout.
    always_comb begin
        state_d     = state_q;
        cnn_start_d = 1'b0;
        cnt_d       = cnt_q;
        led_d       = led_q;
        timeout_d   = timeout_q;
        if (state_q == IDLE) begin
            if (req) begin
                state_d     = RUN;
                cnn_start_d = 1'b1;
                timeout_d   = 1'b0;
                cnt_d       = '0;
            end
        end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
            if (cnn_done) begin
                led_d   = cnn_result;
                state_d = IDLE;
            end else if (expired) begin
                led_d     = '1;
                timeout_d = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk_100m or negedge rst_btn_n) begin
        if (!rst_btn_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            btn_db_q    <= 1'b0;
            btn_prev_q  <= 1'b0;
            db_cnt_q    <= '0;
            cnt_q       <= '0;
            cnn_start_q <= 1'b0;
            timeout_q   <= 1'b0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            btn_db_q    <= btn_db_d;
            btn_prev_q  <= btn_prev_d;
            db_cnt_q    <= db_cnt_d;
            cnt_q       <= cnt_d;
            cnn_start_q <= cnn_start_d;
            timeout_q   <= timeout_d;
            led_q       <= led_d;
        end
    end

`ifdef CNN_RUN_PERF_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    always_comb
        run_cycles_d = (state_q == RUN && cnn_done) ? cnt_q : run_cycles_q;

    always_ff @(posedge clk_100m or negedge rst_btn_n) begin
        if (!rst_btn_n)
            run_cycles_q <= '0;
        else
            run_cycles_q <= run_cycles_d;
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = '0;
`endif

    assign cnn_start  = cnn_start_q;
    assign busy       = (state_q == RUN);
    assign timeout    = timeout_q;
    assign led_result = led_q;

endmodule
